// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte-stream requesters.
// A grant is held for a whole message (through req_last) or revoked by a LOAD timeout.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int unsigned     ID_W     = $clog2(NUM_REQ);
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_BLANK,
        S_WAIT_TX
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_last_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout_err;

    logic              w_found;
    logic [ID_W-1:0]   w_pick;
    logic [ID_W-1:0]   w_next_ptr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_valid;
    logic              w_sel_last;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // First requesting index at or above the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_rr_ptr, k);
            end
        end
    end

    assign w_next_ptr  = (r_grant_id == ID_MAX) ? '0 : r_grant_id + ID_W'(1);
    assign w_sel_data  = req_data[32'(r_grant_id) * DATA_W +: DATA_W];
    assign w_sel_valid = req_valid[r_grant_id];
    assign w_sel_last  = req_last[r_grant_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_tx_data     <= '0;
            r_last_q      <= 1'b0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_sel_valid) begin
                        r_tx_data <= w_sel_data;
                        r_last_q  <= w_sel_last;
                        r_cnt     <= '0;
                        r_state   <= S_SEND;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= w_next_ptr;
                        r_cnt         <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    if (tx_ready) r_state <= S_BLANK;
                end
                // uart_tx needs one cycle to register its busy state.
                S_BLANK: begin
                    r_state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (tx_ready) begin
                        if (r_last_q) begin
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= S_IDLE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode only from registers, so reset clears them immediately.
    assign req_ready   = (r_state == S_LOAD) ? (NUM_REQ'(1) << r_grant_id) : '0;
    assign tx_valid    = (r_state == S_SEND);
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple uart_tx busy/ready model.
module tb_uart_tx_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 8;

    logic                      clk       = 1'b0;
    logic                      rst       = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]        req_last  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready  = 1'b0;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    logic force_low   = 1'b1;
    int   busy_cycles = 20;
    int   acc_cnt     = 0;
    int   seen_cnt    = 0;
    int   busy_left   = 0;
    int   rd          = 0;
    int   base        = 0;
    logic hold_ok     = 1'b1;
    logic [NUM_REQ-1:0] ready_or = '0;
    logic [7:0] sent_data[$];
    logic [1:0] sent_gid[$];

    uart_tx_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Log every byte handed to the uart.
    always @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            sent_data.push_back(tx_data);
            sent_gid.push_back(grant_id);
            acc_cnt++;
        end
    end

    // uart_tx model: busy for busy_cycles after each accepted byte.
    always @(negedge clk) begin
        if (acc_cnt != seen_cnt) begin
            seen_cnt  = acc_cnt;
            busy_left = busy_cycles;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        tx_ready = !force_low && (busy_left == 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
        ready_or = ready_or | req_ready;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy !== 1'b0; i++) step();
        chk(tag, 32'(busy), 32'h0);
    endtask

    task automatic chk_sent(input string tag, input logic [1:0] gid, input logic [7:0] d);
        if (sent_data.size() > rd) begin
            chk({tag, " data"}, 32'(sent_data[rd]), 32'(d));
            chk({tag, " gid"}, 32'(sent_gid[rd]), 32'(gid));
        end else begin
            chk({tag, " present"}, 32'(sent_data.size()), 32'(rd + 1));
        end
        rd++;
    endtask

    // Present one byte, wait for the grant, complete the handshake, drop valid.
    task automatic send_byte(input logic [1:0] id, input logic [7:0] d, input logic l,
                             input string tag);
        req_valid[id]              = 1'b1;
        req_data[32'(id) * 8 +: 8] = d;
        req_last[id]               = l;
        for (int i = 0; i < 300 && req_ready[id] !== 1'b1; i++) step();
        chk({tag, " ready"}, 32'(req_ready[id]), 32'h1);
        step();
        req_valid[id] = 1'b0;
        chk({tag, " tx_valid"}, 32'(tx_valid), 32'h1);
        chk({tag, " tx_data"}, 32'(tx_data), 32'(d));
    endtask

    initial begin
        // Reset values
        step();
        step();
        rst = 1'b0;
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst tx_valid", 32'(tx_valid), 32'h0);
        chk("rst grant_id", 32'(grant_id), 32'h0);
        chk("rst timeout_err", 32'(timeout_err), 32'h0);

        // Reset asserted mid-SEND clears outputs without a clock edge
        req_valid[1]    = 1'b1;
        req_data[15:8]  = 8'h55;
        req_last[1]     = 1'b0;
        step();
        chk("t1 load r1", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        chk("t1 send tx_valid", 32'(tx_valid), 32'h1);
        chk("t1 send data", 32'(tx_data), 32'h55);
        #3;
        rst = 1'b1;
        #1;
        chk("t1 async tx_valid", 32'(tx_valid), 32'h0);
        chk("t1 async req_ready", 32'(req_ready), 32'h0);
        chk("t1 async busy", 32'(busy), 32'h0);
        chk("t1 async tx_data", 32'(tx_data), 32'h0);
        chk("t1 async grant_id", 32'(grant_id), 32'h0);
        step();
        rst       = 1'b0;
        force_low = 1'b0;
        req_valid[2]    = 1'b1;
        req_data[23:16] = 8'h41;
        req_last[2]     = 1'b1;
        step();
        chk("t1 r2 ready", 32'(req_ready), 32'h4);
        chk("t1 r2 grant_id", 32'(grant_id), 32'h2);
        step();
        req_valid[2] = 1'b0;
        chk("t1 r2 tx_valid", 32'(tx_valid), 32'h1);
        chk("t1 r2 tx_data", 32'(tx_data), 32'h41);
        wait_idle("t1 idle");
        chk_sent("t1 byte", 2'd2, 8'h41);

        // Single two-byte message from requester 0, uart busy 20 cycles per byte
        ready_or = '0;
        send_byte(2'd0, 8'h48, 1'b0, "t2 b0");
        send_byte(2'd0, 8'h69, 1'b1, "t2 b1");
        repeat (5) step();
        chk("t2 busy while uart busy", 32'(busy), 32'h1);
        wait_idle("t2 idle");
        chk("t2 only r0 acked", 32'(ready_or), 32'h1);
        chk_sent("t2 b0", 2'd0, 8'h48);
        chk_sent("t2 b1", 2'd0, 8'h69);

        // Non-interleave: requester 3 arrives during requester 1's message
        ready_or = '0;
        base     = acc_cnt;
        send_byte(2'd1, 8'hA1, 1'b0, "t3 b0");
        req_valid[3]    = 1'b1;
        req_data[31:24] = 8'hB3;
        req_last[3]     = 1'b1;
        send_byte(2'd1, 8'hA2, 1'b0, "t3 b1");
        send_byte(2'd1, 8'hA3, 1'b1, "t3 b2");
        chk("t3 r3 held off", 32'(ready_or[3]), 32'h0);
        for (int i = 0; i < 300 && req_ready[3] !== 1'b1; i++) step();
        chk("t3 r3 granted", 32'(req_ready), 32'h8);
        chk("t3 uart idle at r3 grant", 32'(tx_ready), 32'h1);
        chk("t3 r1 bytes done", 32'(acc_cnt), 32'(base + 3));
        step();
        req_valid[3] = 1'b0;
        chk("t3 r3 data", 32'(tx_data), 32'hB3);
        wait_idle("t3 idle");
        chk_sent("t3 s0", 2'd1, 8'hA1);
        chk_sent("t3 s1", 2'd1, 8'hA2);
        chk_sent("t3 s2", 2'd1, 8'hA3);
        chk_sent("t3 s3", 2'd3, 8'hB3);

        // Round-robin fairness with all requesters holding 1-byte messages
        busy_cycles = 2;
        base        = acc_cnt;
        req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
        req_last    = 4'hF;
        req_valid   = 4'hF;
        for (int i = 0; i < 500 && acc_cnt < base + 5; i++) step();
        req_valid = '0;
        chk("t4 five grants", 32'(acc_cnt), 32'(base + 5));
        wait_idle("t4 idle");
        chk_sent("t4 g0", 2'd0, 8'h10);
        chk_sent("t4 g1", 2'd1, 8'h11);
        chk_sent("t4 g2", 2'd2, 8'h12);
        chk_sent("t4 g3", 2'd3, 8'h13);
        chk_sent("t4 g4", 2'd0, 8'h10);

        // Timeout: requester 2 stalls mid-message, pending requester 3 follows
        req_valid[3]    = 1'b1;
        req_data[31:24] = 8'hD3;
        req_last[3]     = 1'b1;
        send_byte(2'd2, 8'hC2, 1'b0, "t5 b0");
        for (int i = 0; i < 100 && req_ready[2] !== 1'b1; i++) step();
        chk("t5 reload r2", 32'(req_ready), 32'h4);
        repeat (7) step();
        chk("t5 still load", 32'(req_ready), 32'h4);
        chk("t5 no early timeout", 32'(timeout_err), 32'h0);
        step();
        chk("t5 timeout pulse", 32'(timeout_err), 32'h1);
        chk("t5 idle on timeout", 32'(busy), 32'h0);
        step();
        chk("t5 pulse one cycle", 32'(timeout_err), 32'h0);
        chk("t5 r3 ready", 32'(req_ready), 32'h8);
        chk("t5 r3 grant_id", 32'(grant_id), 32'h3);
        step();
        req_valid[3] = 1'b0;
        chk("t5 r3 data", 32'(tx_data), 32'hD3);
        wait_idle("t5 idle");
        chk_sent("t5 s0", 2'd2, 8'hC2);
        chk_sent("t5 s1", 2'd3, 8'hD3);

        // Back-pressure: tx_ready low for 100 cycles during SEND
        force_low = 1'b1;
        step();
        step();
        base    = acc_cnt;
        hold_ok = 1'b1;
        send_byte(2'd0, 8'hE0, 1'b1, "t6 b0");
        for (int i = 0; i < 100; i++) begin
            step();
            if (!(tx_valid === 1'b1 && tx_data === 8'hE0)) hold_ok = 1'b0;
        end
        chk("t6 held stable", 32'(hold_ok), 32'h1);
        chk("t6 no accept while low", 32'(acc_cnt), 32'(base));
        force_low = 1'b0;
        step();
        chk("t6 accepted once", 32'(acc_cnt), 32'(base + 1));
        chk("t6 tx_valid drops", 32'(tx_valid), 32'h0);
        wait_idle("t6 idle");
        chk("t6 still one accept", 32'(acc_cnt), 32'(base + 1));
        chk_sent("t6 s0", 2'd0, 8'hE0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single `uart_tx` transmitter among `NUM_REQ` byte-stream requesters. Each requester presents bytes with a valid/ready handshake and marks the final byte of a message with `req_last`. The grant is held for a whole message, so messages from different sources never interleave on the serial line. The block sits between the on-chip byte producers and `uart_tx`, and drives its `tx_valid`/`tx_data` inputs from its `tx_ready` output.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `DATA_W`, 8: byte width, matches `uart_tx`
- `TIMEOUT`, 1023: LOAD-state cycles without `req_valid` before the grant is revoked (≥1)
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester byte valid
- `req_data`  in  NUM_REQ*DATA_W  packed bytes; requester i at `[i*DATA_W +: DATA_W]`
- `req_last`  in  NUM_REQ  byte is the last of its message
- `req_ready`  out  NUM_REQ  one-hot; byte taken when `req_valid[i] & req_ready[i]`
- `tx_valid`  out  1  to `uart_tx`
- `tx_data`  out  DATA_W  to `uart_tx`, registered
- `tx_ready`  in  1  from `uart_tx`; high = idle, can accept
- `grant_id`  out  clog2(NUM_REQ)  current/last granted requester
- `busy`  out  1  high in any state except IDLE
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- States: IDLE, LOAD, SEND, BLANK, WAIT_TX.
- IDLE: if any `req_valid`, pick the first set bit searching from `rr_ptr` upward, with wrap-around. Register it into `grant_id`, then go to LOAD. With no requests, stay in IDLE.
- LOAD: `req_ready[grant_id]=1`, all other bits 0.
  - On handshake: capture data into `tx_data` and `req_last` into `last_q`, clear the timeout counter, go to SEND.
  - Each cycle without `req_valid[grant_id]`: increment the counter. When the counter reaches `TIMEOUT`, pulse `timeout_err`, set `rr_ptr=grant_id+1` (mod NUM_REQ), go to IDLE.
- SEND: `tx_valid=1`. Hold `tx_data` stable until `tx_valid & tx_ready`, then go to BLANK.
- BLANK: exactly one cycle. `tx_ready` is ignored here, giving `uart_tx` time to register busy. Then go to WAIT_TX.
- WAIT_TX: wait for `tx_ready=1`.
  - If `last_q`: set `rr_ptr=grant_id+1` (mod NUM_REQ), go to IDLE.
  - Otherwise: go to LOAD, keeping the same grant.
- Only the granted requester is ever acknowledged. Requests from others during a message are held off, not dropped.
- `rr_ptr` advances only at message end or timeout. This guarantees each active requester is served within NUM_REQ messages.
- Changes to `req_valid` on non-granted lines have no effect outside IDLE.
- Reset (at any time, including mid-message): state=IDLE, `rr_ptr=0`, `grant_id=0`, `tx_data=0`, `last_q=0`, timeout counter=0. All outputs go low immediately: `req_ready=0`, `tx_valid=0`, `busy=0`, `timeout_err=0`.
  - A byte already handed to `uart_tx` is not the scheduler's concern.
  - A partially sent message is abandoned; the requester must restart it.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from `req_*` or `tx_ready` to any output.
- First-byte latency: `req_valid` high in IDLE at cycle 0 → LOAD with `req_ready` high at cycle 1 → `tx_valid` high at cycle 2.
- `tx_valid` drops the cycle after acceptance.
- Next `req_ready` for the same message: earliest 3 cycles after acceptance (BLANK, WAIT_TX seeing `tx_ready`, then LOAD).
- After a message ends or times out, IDLE re-arbitrates on the next cycle. Minimum gap between messages of different requesters: 2 cycles.
- Timeout fires on the `TIMEOUT`-th consecutive LOAD cycle without valid. `timeout_err` is high for the one cycle when the state is IDLE.
- Simultaneous requests in IDLE: the lowest index at or above `rr_ptr` wins, with wrap-around.

## Test plan
- Reset: assert `rst` mid-SEND → `tx_valid`, `req_ready`, `busy` go 0 asynchronously. After release, requester 2 sending 0x41 is granted, `grant_id=2`, and `tx_data=0x41` appears 2 cycles after `req_valid`.
- Single message: requester 0 sends 0x48,0x69(last) with a `tx_ready` model busy 20 cycles per byte → `tx_data` sequence 0x48,0x69. `busy` drops after the second byte's `tx_ready` returns. `rr_ptr=1`.
- Non-interleave: requester 1 sends a 3-byte message while requester 3 raises `req_valid` after byte 1 → serial order is 1,1,1 then 3. `req_ready[3]` stays 0 until requester 1's last byte completes.
- Round-robin fairness: all 4 requesters hold `req_valid` with 1-byte messages (data 0x10+i) → grant order 0,1,2,3,0. No requester is granted twice before the others have each been granted once.
- Timeout: `TIMEOUT=8`, requester 2 sends a non-last byte and then drops valid → `timeout_err` pulses 8 cycles into LOAD. Pending requester 3 is granted next, `grant_id=3`.
- Back-pressure: `tx_ready` held low for 100 cycles during SEND → `tx_valid` stays 1 and `tx_data` stays unchanged. Exactly one acceptance occurs when `tx_ready` rises.
